// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with valid/ready handshake and a two-entry skid buffer.
// Define ID_EXE_PIPE_STATS_EN to enable the stall/flush statistics counters.
module id_exe_pipe_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CMD_W      = 4,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned SHIFT_W    = 12,
    parameter int unsigned IMM_W      = 24,
    parameter int unsigned SR_W       = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_ctrl,
    input  logic [CMD_W-1:0]      in_exe_cmd,
    input  logic [DATA_W-1:0]     in_val_rn,
    input  logic [DATA_W-1:0]     in_val_rm,
    input  logic [SHIFT_W-1:0]    in_shift_operand,
    input  logic [IMM_W-1:0]      in_signed_imm,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [SR_W-1:0]       in_sr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_ctrl,
    output logic [CMD_W-1:0]      out_exe_cmd,
    output logic [DATA_W-1:0]     out_val_rn,
    output logic [DATA_W-1:0]     out_val_rm,
    output logic [SHIFT_W-1:0]    out_shift_operand,
    output logic [IMM_W-1:0]      out_signed_imm,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [PC_W-1:0]       out_pc,
    output logic [SR_W-1:0]       out_sr,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic [5:0]            ctrl;
        logic [CMD_W-1:0]      exe_cmd;
        logic [DATA_W-1:0]     val_rn;
        logic [DATA_W-1:0]     val_rm;
        logic [SHIFT_W-1:0]    shift_operand;
        logic [IMM_W-1:0]      signed_imm;
        logic [REG_ADDR_W-1:0] dest;
        logic [PC_W-1:0]       pc;
        logic [SR_W-1:0]       sr;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   out_valid_q;
    logic   in_ready_q;
    logic   in_xfer;
    logic   out_xfer;

    assign in_entry = '{
        ctrl:          in_ctrl,
        exe_cmd:       in_exe_cmd,
        val_rn:        in_val_rn,
        val_rm:        in_val_rm,
        shift_operand: in_shift_operand,
        signed_imm:    in_signed_imm,
        dest:          in_dest,
        pc:            in_pc,
        sr:            in_sr
    };

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Handshake flags are flopped alongside the state so neither depends on the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_q      <= '0;
            main_q.dest <= '1;
            skid_q      <= '0;
        end else if (flush) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_q      <= in_entry;
                        state_q     <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_entry;
                    end else if (in_xfer) begin
                        skid_q     <= in_entry;
                        state_q    <= StTwo;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        state_q    <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    // Bubble: control and destination are neutralised whenever nothing is held.
    assign out_ctrl          = out_valid_q ? main_q.ctrl : '0;
    assign out_dest          = out_valid_q ? main_q.dest : '1;
    assign out_exe_cmd       = main_q.exe_cmd;
    assign out_val_rn        = main_q.val_rn;
    assign out_val_rm        = main_q.val_rm;
    assign out_shift_operand = main_q.shift_operand;
    assign out_signed_imm    = main_q.signed_imm;
    assign out_pc            = main_q.pc;
    assign out_sr            = main_q.sr;

`ifdef ID_EXE_PIPE_STATS_EN
    localparam int unsigned CNT_W1 = CNT_W + 1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [1:0]       held;
    logic [CNT_W:0]   flush_sum;

    always_comb begin
        held = 2'd0;
        unique case (state_q)
            StEmpty: held = 2'd0;
            StOne:   held = 2'd1;
            StTwo:   held = 2'd2;
            default: held = 2'd0;
        endcase
    end

    assign flush_sum = {1'b0, flush_q} + CNT_W1'(held);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush) begin
                flush_q <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Scoreboard bench for id_exe_pipe_reg: a queue model of held instructions checked every cycle.
module tb_id_exe_pipe_reg;

`ifdef ID_EXE_PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [3:0]  cmd;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] sh;
        logic [23:0] imm;
        logic [3:0]  dest;
        logic [31:0] pc;
        logic [3:0]  sr;
    } entry_t;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_ctrl = '0;
    logic [3:0]  in_exe_cmd = '0;
    logic [31:0] in_val_rn = '0;
    logic [31:0] in_val_rm = '0;
    logic [11:0] in_shift_operand = '0;
    logic [23:0] in_signed_imm = '0;
    logic [3:0]  in_dest = '0;
    logic [31:0] in_pc = '0;
    logic [3:0]  in_sr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_ctrl;
    logic [3:0]  out_exe_cmd;
    logic [31:0] out_val_rn;
    logic [31:0] out_val_rm;
    logic [11:0] out_shift_operand;
    logic [23:0] out_signed_imm;
    logic [3:0]  out_dest;
    logic [31:0] out_pc;
    logic [3:0]  out_sr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    id_exe_pipe_reg dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_ctrl           (in_ctrl),
        .in_exe_cmd        (in_exe_cmd),
        .in_val_rn         (in_val_rn),
        .in_val_rm         (in_val_rm),
        .in_shift_operand  (in_shift_operand),
        .in_signed_imm     (in_signed_imm),
        .in_dest           (in_dest),
        .in_pc             (in_pc),
        .in_sr             (in_sr),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_ctrl          (out_ctrl),
        .out_exe_cmd       (out_exe_cmd),
        .out_val_rn        (out_val_rn),
        .out_val_rm        (out_val_rm),
        .out_shift_operand (out_shift_operand),
        .out_signed_imm    (out_signed_imm),
        .out_dest          (out_dest),
        .out_pc            (out_pc),
        .out_sr            (out_sr),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    always #5 clk = clk_en ? ~clk : clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    entry_t      q[$];
    entry_t      last;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic entry_t mk(input logic [31:0] pc);
        entry_t e;
        e.ctrl = pc[7:2] ^ 6'h2A;
        e.cmd  = pc[5:2] ^ 4'h9;
        e.rn   = pc * 3 + 32'h1111;
        e.rm   = ~pc;
        e.sh   = pc[11:0] ^ 12'h5A5;
        e.imm  = 24'h800000 - pc[23:0];
        e.dest = pc[5:2];
        e.pc   = pc;
        e.sr   = pc[7:4] ^ 4'h6;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc);
        entry_t e;
        e = v ? mk(pc) : mk(32'hDEAD_BEEC);
        in_valid         = v;
        in_ctrl          = e.ctrl;
        in_exe_cmd       = e.cmd;
        in_val_rn        = e.rn;
        in_val_rm        = e.rm;
        in_shift_operand = e.sh;
        in_signed_imm    = e.imm;
        in_dest          = e.dest;
        in_pc            = e.pc;
        in_sr            = e.sr;
    endtask

    task automatic check_all();
        entry_t h;
        bit     v;
        v = q.size() > 0;
        h = v ? q[0] : last;
        if (!v) begin
            h.ctrl = '0;
            h.dest = '1;
        end
        chk("out_valid", out_valid, v);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_ctrl", out_ctrl, h.ctrl);
        chk("out_exe_cmd", out_exe_cmd, h.cmd);
        chk("out_val_rn", out_val_rn, h.rn);
        chk("out_val_rm", out_val_rm, h.rm);
        chk("out_shift_operand", out_shift_operand, h.sh);
        chk("out_signed_imm", out_signed_imm, h.imm);
        chk("out_dest", out_dest, h.dest);
        chk("out_pc", out_pc, h.pc);
        chk("out_sr", out_sr, h.sr);
        chk("stall_cnt", stall_cnt, STATS ? m_stall : 0);
        chk("flush_cnt", flush_cnt, STATS ? m_flush : 0);
    endtask

    // Advance the model by one edge using the currently driven inputs, then compare.
    task automatic cyc();
        int unsigned sz;
        bit          in_x;
        bit          out_x;
        sz    = q.size();
        in_x  = in_valid && (sz < 2);
        out_x = (sz > 0) && out_ready;
        if ((sz > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall++;
        if (flush) begin
            m_flush = (m_flush + sz > 16'hFFFF) ? 16'hFFFF : m_flush + sz;
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(mk(in_pc));
        end
        if (q.size() > 0) last = q[0];
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        last    = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        drive(1'b0, 32'h0);
        model_reset();
        // Reset with the clock stopped
        #2 rst = 1'b1;
        #1 check_all();
        clk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        // Streaming
        out_ready = 1'b1;
        drive(1'b1, 32'h0);  cyc();
        drive(1'b1, 32'h4);  cyc();
        drive(1'b1, 32'h8);  cyc();
        drive(1'b0, 32'h0);  cyc();
        chk("stream_stall_zero", stall_cnt, 0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h10); cyc();
        drive(1'b1, 32'h14); cyc();
        chk("bp_in_ready_low", in_ready, 0);
        drive(1'b1, 32'h18); cyc();
        drive(1'b0, 32'h0);  cyc();
        out_ready = 1'b1;
        cyc();
        chk("bp_second_out", out_pc, 32'h14);
        cyc();
        chk("bp_stall_held", stall_cnt, STATS ? 3 : 0);

        // Flush in TWO with an instruction presented
        out_ready = 1'b0;
        drive(1'b1, 32'h1C); cyc();
        drive(1'b1, 32'h24); cyc();
        drive(1'b1, 32'h20);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("flush_cnt_two", flush_cnt, STATS ? 2 : 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("no_pc_0x20", out_valid && (out_pc == 32'h20), 0);
        end

        // Simultaneous input and output transfer in ONE
        out_ready = 1'b0;
        drive(1'b1, 32'h30); cyc();
        out_ready = 1'b1;
        drive(1'b1, 32'h34); cyc();
        chk("sim_pc", out_pc, 32'h34);
        drive(1'b0, 32'h0);  cyc();

        // Random traffic with occasional flushes
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h100 + 32'(i) * 4);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset while holding two entries
        out_ready = 1'b0;
        drive(1'b1, 32'h200); cyc();
        drive(1'b1, 32'h204); cyc();
        drive(1'b0, 32'h0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h300); cyc();
        drive(1'b0, 32'h0);   cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

Parametrised ID→EXE pipeline register with a valid/ready handshake and a two-entry skid buffer, replacing the fixed-width, always-advancing decode/execute latch. It sits between the decode stage and the execute stage. It carries decoded control, operands, shifter operand, branch immediate, destination, PC and status bits. It supports backpressure from EXE, a synchronous flush on taken branches, and bubble injection whenever no instruction is held.

## Interface
- DATA_W, 32, operand width (val_rn, val_rm)
- PC_W, 32, program counter width
- CMD_W, 4, execute command width
- REG_ADDR_W, 4, register address width (dest)
- SHIFT_W, 12, shifter operand width
- IMM_W, 24, signed branch immediate width
- SR_W, 4, status register (NZCV) width
- CNT_W, 16, statistics counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all held instructions (synchronous)
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  register can accept this cycle
- in_ctrl  in  6  {wb_en, mem_r_en, mem_w_en, b, s, imm}, bit 5 = wb_en
- in_exe_cmd  in  CMD_W  execute command
- in_val_rn, in_val_rm  in  DATA_W  register operands
- in_shift_operand  in  SHIFT_W  shifter operand
- in_signed_imm  in  IMM_W  branch offset
- in_dest  in  REG_ADDR_W  destination register
- in_pc  in  PC_W  PC of the instruction
- in_sr  in  SR_W  status flags
- out_valid  out  1  EXE holds a valid instruction
- out_ready  in  1  EXE consumes this cycle
- out_ctrl, out_exe_cmd, out_val_rn, out_val_rm, out_shift_operand, out_signed_imm, out_dest, out_pc, out_sr  out  (widths as inputs)  head-entry fields
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_W  valid entries discarded by flush

## Operation
- Storage consists of a main entry (drives out_*) and a skid entry. The states are EMPTY, ONE and TWO.
- EMPTY: out_valid=0, in_ready=1. An input transfer (in_valid & in_ready) moves to ONE.
- ONE: out_valid=1, in_ready=1.
  - Input transfer only: the new instruction goes to skid; move to TWO.
  - Output transfer (out_valid & out_ready) only: move to EMPTY.
  - Both: main is replaced by the input; stay in ONE.
- TWO: out_valid=1, in_ready=0. An output transfer moves skid into main; move to ONE.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- flush has the highest priority. It empties both entries next edge and returns to EMPTY. An input transfer in the same cycle is discarded. flush_cnt increments by the number of valid entries discarded (0, 1 or 2).
- Bubble rule: whenever out_valid=0, out_ctrl=0 and out_dest=all-ones. Other out_* fields hold their last value.
- Counters saturate at 2^CNT_W-1. They are cleared only by rst.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N. Sustained throughput is 1 per cycle with out_ready=1.
- in_ready and out_valid are pure register outputs, with no combinational path from out_ready or in_valid.
- Reset (async) values: state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_exe_cmd=0, out_val_rn=0, out_val_rm=0, out_shift_operand=0, out_signed_imm=0, out_pc=0, out_sr=0, out_dest=all-ones, stall_cnt=0, flush_cnt=0.
- Reset asserted mid-transfer loses all entries immediately, without waiting for a clock edge.
- in_* fields are sampled only on an input transfer. out_* fields are stable while out_valid=1 and out_ready=0.

## Configuration
- ID_EXE_PIPE_STATS_EN defined: stall_cnt and flush_cnt count as specified above.
- ID_EXE_PIPE_STATS_EN undefined: counter logic is absent, stall_cnt and flush_cnt are tied to 0, and the ports remain.

## Test plan
- Reset with clk stopped: after rst=1, out_valid=0, in_ready=1, out_dest=4'hF, out_ctrl=0, and every other output is 0.
- Streaming: with out_ready=1, present PCs 0x0, 0x4 and 0x8 on consecutive cycles. out_pc must show 0x0, 0x4 and 0x8 one cycle later each, and stall_cnt stays 0.
- Backpressure: with out_ready=0, push 0x10 then 0x14. in_ready must drop after the second transfer. Raise out_ready: 0x10 then 0x14 emerge, and stall_cnt equals the held cycles.
- Flush in TWO with in_valid=1 (PC 0x20): next cycle out_valid=0, out_ctrl=0, out_dest=4'hF, flush_cnt=2, and 0x20 never appears.
- Simultaneous in and out in ONE: main holds 0x30, present 0x34 with out_ready=1. The next cycle shows out_pc=0x34, state ONE, in_ready=1.
- With the macro undefined, repeat the backpressure test: stall_cnt and flush_cnt remain 0.
